// File: rtl/cache_fill_lru.sv
// Fill side of the LRU line store: victim pick by age, beat fetch over req/ack, one-cycle line write.
// Optional macro CACHE_FILL_CRIT_WORD_EN adds miss_blk and fetches beats starting at that block.
module cache_fill_lru #(
   parameter  int DEPTH            = 7,
   parameter  int TAG_BITS         = 30,
   parameter  int NUM_BLOCKS       = 4,
   parameter  int BLOCK_SIZE_BYTES = 8,
   localparam int IDX_W            = $clog2(DEPTH),
   localparam int BLK_W            = $clog2(NUM_BLOCKS),
   localparam int BLK_BITS         = 8 * BLOCK_SIZE_BYTES,
   localparam int DATA_BITS        = TAG_BITS + NUM_BLOCKS * BLK_BITS,
   localparam int ADDR_BITS        = TAG_BITS + BLK_W
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 miss_valid,
   output logic                 miss_ready,
   input  logic [TAG_BITS-1:0]  miss_tag,
`ifdef CACHE_FILL_CRIT_WORD_EN
   input  logic [BLK_W-1:0]     miss_blk,
`endif
   input  logic                 hit_valid,
   input  logic [IDX_W-1:0]     hit_idx,
   output logic                 mem_req,
   output logic [ADDR_BITS-1:0] mem_addr,
   input  logic                 mem_ack,
   input  logic [BLK_BITS-1:0]  mem_rdata,
   output logic                 wr_en,
   output logic [IDX_W-1:0]     wr_idx,
   output logic [DATA_BITS-1:0] wr_line,
   output logic [DEPTH-1:0]     line_valid,
   output logic                 fill_done,
   output logic                 busy
);

   typedef enum logic [1:0] {S_IDLE, S_VICTIM, S_FETCH, S_WRITE} state_e;

   state_e                          state_q;
   logic                            miss_ready_q, busy_q, mem_req_q, wr_en_q, fill_done_q;
   logic [ADDR_BITS-1:0]            mem_addr_q;
   logic [IDX_W-1:0]                wr_idx_q, victim_q, victim_d;
   logic [DATA_BITS-1:0]            wr_line_q;
   logic [TAG_BITS-1:0]             tag_q;
   logic [BLK_W-1:0]                blk_q, blk_nxt, blk_start;
   logic [BLK_W-1:0]                beat_cnt_q;
   logic [NUM_BLOCKS*BLK_BITS-1:0]  line_buf_q, line_buf_d;
   logic [DEPTH-1:0]                valid_q, valid_d;
   logic [IDX_W-1:0]                age_q [DEPTH];
   logic [IDX_W-1:0]                age_d [DEPTH];
   logic                            hit_ok, acc_en, found;
   logic [IDX_W-1:0]                acc_idx;

`ifdef CACHE_FILL_CRIT_WORD_EN
   assign blk_start = miss_blk;
`else
   assign blk_start = '0;
`endif

   assign blk_nxt = (blk_q == BLK_W'(NUM_BLOCKS - 1)) ? '0 : blk_q + BLK_W'(1);
   assign hit_ok  = hit_valid && (32'(hit_idx) < 32'(DEPTH));

   // Lowest-index invalid line first; otherwise the oldest, whose age is always DEPTH-1.
   always_comb begin
      victim_d = '0;
      found    = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (!valid_q[i] && !found) begin
            victim_d = IDX_W'(i);
            found    = 1'b1;
         end
      end
      if (!found) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (age_q[i] == IDX_W'(DEPTH - 1)) victim_d = IDX_W'(i);
         end
      end
   end

   always_comb begin
      line_buf_d = line_buf_q;
      line_buf_d[int'(blk_q)*BLK_BITS +: BLK_BITS] = mem_rdata;
   end

   // A fill in WRITE is the only access that cycle; hits arriving then are dropped.
   always_comb begin
      age_d   = age_q;
      valid_d = valid_q;
      acc_en  = 1'b0;
      acc_idx = '0;
      if (state_q == S_WRITE) begin
         acc_en           = 1'b1;
         acc_idx          = victim_q;
         valid_d[victim_q] = 1'b1;
      end else if (hit_ok) begin
         acc_en  = 1'b1;
         acc_idx = hit_idx;
      end
      if (acc_en) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (age_q[i] < age_q[acc_idx]) age_d[i] = age_q[i] + IDX_W'(1);
         end
         age_d[acc_idx] = '0;
      end
   end

   // NOTE: the age table is reset too; reset must restore distinct ages and invalidate every line.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         miss_ready_q <= 1'b1;
         busy_q       <= 1'b0;
         mem_req_q    <= 1'b0;
         mem_addr_q   <= '0;
         wr_en_q      <= 1'b0;
         fill_done_q  <= 1'b0;
         wr_idx_q     <= '0;
         wr_line_q    <= '0;
         tag_q        <= '0;
         blk_q        <= '0;
         beat_cnt_q   <= '0;
         victim_q     <= '0;
         line_buf_q   <= '0;
         valid_q      <= '0;
         for (int i = 0; i < DEPTH; i++) age_q[i] <= IDX_W'(i);
      end else begin
         valid_q <= valid_d;
         age_q   <= age_d;
         case (state_q)
            S_IDLE: begin
               if (miss_valid) begin
                  tag_q        <= miss_tag;
                  blk_q        <= blk_start;
                  miss_ready_q <= 1'b0;
                  busy_q       <= 1'b1;
                  state_q      <= S_VICTIM;
               end
            end
            S_VICTIM: begin
               victim_q   <= victim_d;
               beat_cnt_q <= '0;
               mem_req_q  <= 1'b1;
               mem_addr_q <= {tag_q, blk_q};
               state_q    <= S_FETCH;
            end
            S_FETCH: begin
               if (mem_ack) begin
                  line_buf_q <= line_buf_d;
                  if (beat_cnt_q == BLK_W'(NUM_BLOCKS - 1)) begin
                     mem_req_q   <= 1'b0;
                     wr_en_q     <= 1'b1;
                     fill_done_q <= 1'b1;
                     wr_idx_q    <= victim_q;
                     wr_line_q   <= {tag_q, line_buf_d};
                     state_q     <= S_WRITE;
                  end else begin
                     beat_cnt_q <= beat_cnt_q + BLK_W'(1);
                     blk_q      <= blk_nxt;
                     mem_addr_q <= {tag_q, blk_nxt};
                  end
               end
            end
            S_WRITE: begin
               wr_en_q      <= 1'b0;
               fill_done_q  <= 1'b0;
               miss_ready_q <= 1'b1;
               busy_q       <= 1'b0;
               state_q      <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign miss_ready = miss_ready_q;
   assign busy       = busy_q;
   assign mem_req    = mem_req_q;
   assign mem_addr   = mem_addr_q;
   assign wr_en      = wr_en_q;
   assign fill_done  = fill_done_q;
   assign wr_idx     = wr_idx_q;
   assign wr_line    = wr_line_q;
   assign line_valid = valid_q;

endmodule

// File: tb/tb_cache_fill_lru.sv
// Directed bench for cache_fill_lru: scoreboard of expected line writes, memory responder with
// configurable ack delay, LRU victim order, held misses, reset abort and critical-word order.
module tb_cache_fill_lru;

   localparam int DEPTH      = 7;
   localparam int TAG_BITS   = 30;
   localparam int NUM_BLOCKS = 4;
   localparam int IDX_W      = 3;
   localparam int BLK_W      = 2;
   localparam int BLK_BITS   = 64;
   localparam int DATA_BITS  = TAG_BITS + NUM_BLOCKS * BLK_BITS;
   localparam int ADDR_BITS  = TAG_BITS + BLK_W;

   logic                 clk, rst;
   logic                 miss_valid, miss_ready;
   logic [TAG_BITS-1:0]  miss_tag;
   logic [BLK_W-1:0]     miss_blk_v;
   logic                 hit_valid;
   logic [IDX_W-1:0]     hit_idx;
   logic                 mem_req, mem_ack;
   logic [ADDR_BITS-1:0] mem_addr;
   logic [BLK_BITS-1:0]  mem_rdata;
   logic                 wr_en, fill_done, busy;
   logic [IDX_W-1:0]     wr_idx;
   logic [DATA_BITS-1:0] wr_line;
   logic [DEPTH-1:0]     line_valid;

   typedef struct {
      logic [IDX_W-1:0]     idx;
      logic [DATA_BITS-1:0] line;
      int                   t_acc;
      int                   lat;
   } exp_t;

   exp_t                 sb[$];
   logic [ADDR_BITS-1:0] addr_log[$];
   logic [ADDR_BITS-1:0] held_addr;
   int errors = 0, checks = 0, cyc = 0, fills = 0, ack_delay = 0, wait_cnt = 0;

   cache_fill_lru dut (
      .clk        (clk),
      .rst        (rst),
      .miss_valid (miss_valid),
      .miss_ready (miss_ready),
      .miss_tag   (miss_tag),
`ifdef CACHE_FILL_CRIT_WORD_EN
      .miss_blk   (miss_blk_v),
`endif
      .hit_valid  (hit_valid),
      .hit_idx    (hit_idx),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_ack    (mem_ack),
      .mem_rdata  (mem_rdata),
      .wr_en      (wr_en),
      .wr_idx     (wr_idx),
      .wr_line    (wr_line),
      .line_valid (line_valid),
      .fill_done  (fill_done),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [BLK_BITS-1:0] data_of(input logic [TAG_BITS-1:0] tag,
                                                   input logic [BLK_W-1:0] blk);
      return {32'hD00D_0000 | 32'(blk), 2'b00, tag};
   endfunction

   function automatic logic [DATA_BITS-1:0] exp_line(input logic [TAG_BITS-1:0] tag);
      return {tag, data_of(tag, 2'd3), data_of(tag, 2'd2), data_of(tag, 2'd1), data_of(tag, 2'd0)};
   endfunction

   // Backing memory: acks a beat ack_delay cycles after its request appears.
   initial begin
      mem_ack   = 1'b0;
      mem_rdata = '0;
      held_addr = '0;
      forever begin
         @(negedge clk);
         if (mem_req === 1'b1) begin
            if (wait_cnt == 0) held_addr = mem_addr;
            else check("addr_stable", 512'(mem_addr), 512'(held_addr));
            if (wait_cnt >= ack_delay) begin
               mem_ack   = 1'b1;
               mem_rdata = data_of(mem_addr[ADDR_BITS-1:BLK_W], mem_addr[BLK_W-1:0]);
               addr_log.push_back(mem_addr);
               wait_cnt  = 0;
            end else begin
               mem_ack = 1'b0;
               wait_cnt++;
            end
         end else begin
            mem_ack  = 1'b0;
            wait_cnt = 0;
         end
      end
   end

   // Write monitor: pops the scoreboard on every line write.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (wr_en === 1'b1) begin
            fills++;
            if (sb.size() == 0) begin
               check("wr_unexpected", 512'(wr_en), 512'(0));
            end else begin
               e = sb.pop_front();
               check("wr_idx", 512'(wr_idx), 512'(e.idx));
               check("wr_line", 512'(wr_line), 512'(e.line));
               check("fill_done", 512'(fill_done), 512'(1));
               check("wr_latency", 512'(cyc - e.t_acc), 512'(e.lat));
            end
         end
      end
   end

   task automatic start_miss(input logic [TAG_BITS-1:0] tag, input logic [BLK_W-1:0] blk,
                             input int idx, input int lat, input bit push);
      exp_t e;
      int   guard;
      guard = 0;
      @(negedge clk);
      miss_valid = 1'b1;
      miss_tag   = tag;
      miss_blk_v = blk;
      while (miss_ready !== 1'b1 && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      check("miss_accept_bound", 512'(miss_ready), 512'(1));
      if (push) begin
         e.idx   = IDX_W'(idx);
         e.line  = exp_line(tag);
         e.t_acc = cyc;
         e.lat   = lat;
         sb.push_back(e);
      end
      @(negedge clk);
      miss_valid = 1'b0;
   endtask

   task automatic wait_fill(input int target, input int budget);
      int guard;
      guard = 0;
      while (fills < target && guard < budget) begin
         @(negedge clk);
         guard++;
      end
      check("fill_bound", 512'(fills >= target), 512'(1));
   endtask

   task automatic pulse_hit(input logic [IDX_W-1:0] idx);
      @(negedge clk);
      hit_valid = 1'b1;
      hit_idx   = idx;
      @(negedge clk);
      hit_valid = 1'b0;
   endtask

   task automatic check_addr_order(input logic [TAG_BITS-1:0] tag, input logic [BLK_W-1:0] first);
      logic [BLK_W-1:0] b;
      check("addr_log_len", 512'(addr_log.size()), 512'(NUM_BLOCKS));
      b = first;
      for (int i = 0; i < NUM_BLOCKS && i < addr_log.size(); i++) begin
         check("addr_order", 512'(addr_log[i]), 512'({tag, b}));
         b = b + BLK_W'(1);
      end
   endtask

   initial begin
      exp_t e;
      int   fd_cyc, acc_cyc, guard, fills_before;
      rst        = 1'b1;
      miss_valid = 1'b0;
      miss_tag   = '0;
      miss_blk_v = '0;
      hit_valid  = 1'b0;
      hit_idx    = '0;
      repeat (3) @(negedge clk);
      check("rst_miss_ready", 512'(miss_ready), 512'(1));
      check("rst_mem_req", 512'(mem_req), 512'(0));
      check("rst_wr_en", 512'(wr_en), 512'(0));
      check("rst_fill_done", 512'(fill_done), 512'(0));
      check("rst_busy", 512'(busy), 512'(0));
      check("rst_line_valid", 512'(line_valid), 512'(0));
      check("rst_wr_idx", 512'(wr_idx), 512'(0));
      check("rst_wr_line", 512'(wr_line), 512'(0));
      check("rst_mem_addr", 512'(mem_addr), 512'(0));
      rst = 1'b0;

      // Seven misses into an empty store fill lines 0..6 in order, ack every cycle.
      ack_delay = 0;
      for (int i = 0; i < DEPTH; i++) begin
         start_miss(TAG_BITS'(i + 1), '0, i, 6, 1'b1);
         wait_fill(i + 1, 50);
      end
      @(negedge clk);
      check("all_valid", 512'(line_valid), 512'(7'h7F));

      // Hit line 0; line 1 is now the oldest.
      pulse_hit(3'd0);
      start_miss(30'h8, '0, 1, 6, 1'b1);
      wait_fill(8, 50);

      // Out-of-range hit ignored; slow memory (ack 3 cycles after each request).
      pulse_hit(3'd7);
      ack_delay = 3;
      addr_log.delete();
      start_miss(30'h9, '0, 2, 18, 1'b1);
      wait_fill(9, 80);
      check_addr_order(30'h9, 2'd0);

      // Miss held during a fill; a hit during WRITE must be dropped.
      ack_delay = 0;
      start_miss(30'hA, '0, 3, 6, 1'b1);
      miss_valid = 1'b1;
      miss_tag   = 30'hB;
      fd_cyc  = -100;
      acc_cyc = -1;
      guard   = 0;
      while (guard < 100) begin
         @(negedge clk);
         guard++;
         hit_valid = 1'b0;
         if (fill_done === 1'b1) begin
            fd_cyc    = cyc;
            hit_valid = 1'b1;
            hit_idx   = 3'd4;
         end else if (miss_ready === 1'b1) begin
            acc_cyc = cyc;
            break;
         end
      end
      check("held_miss_accept", 512'(acc_cyc - fd_cyc), 512'(1));
      e.idx   = 3'd4;
      e.line  = exp_line(30'hB);
      e.t_acc = acc_cyc;
      e.lat   = 6;
      sb.push_back(e);
      @(negedge clk);
      miss_valid = 1'b0;
      // A hit during FETCH counts: line 5 becomes youngest, line 6 the next victim.
      @(negedge clk);
      pulse_hit(3'd5);
      wait_fill(11, 50);
      start_miss(30'hC, '0, 6, 6, 1'b1);
      wait_fill(12, 50);

      // Reset during beat 2 aborts the fill.
      ack_delay = 3;
      addr_log.delete();
      fills_before = fills;
      start_miss(30'hD, '0, 5, 18, 1'b0);
      guard = 0;
      while (addr_log.size() < 2 && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      check("beat2_bound", 512'(addr_log.size()), 512'(2));
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("abort_mem_req", 512'(mem_req), 512'(0));
      check("abort_wr_en", 512'(wr_en), 512'(0));
      check("abort_fill_done", 512'(fill_done), 512'(0));
      check("abort_line_valid", 512'(line_valid), 512'(0));
      check("abort_miss_ready", 512'(miss_ready), 512'(1));
      check("abort_busy", 512'(busy), 512'(0));
      rst = 1'b0;
      repeat (30) @(negedge clk);
      check("abort_no_write", 512'(fills), 512'(fills_before));

      // After reset the store is empty again: next fill goes to line 0.
      ack_delay = 0;
      start_miss(30'hE, '0, 0, 6, 1'b1);
      wait_fill(fills_before + 1, 50);
      @(negedge clk);
      check("valid_after_reset", 512'(line_valid), 512'(7'h01));

`ifdef CACHE_FILL_CRIT_WORD_EN
      addr_log.delete();
      start_miss(30'hF, 2'd2, 1, 6, 1'b1);
      wait_fill(fills_before + 2, 50);
      check_addr_order(30'hF, 2'd2);
`endif

      check("sb_drained", 512'(sb.size()), 512'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
